// File: rtl/orbit_plot_pkg.sv
// Shared constants, FSM state type and screen-centre helpers for the orbit trail plotter.
package orbit_plot_pkg;

  localparam int H_DISPLAY_DEF = 640;
  localparam int V_DISPLAY_DEF = 480;
  localparam int FB_ADDR_W     = 19;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAP,
    ST_ERASE,
    ST_DRAW,
    ST_CLEAR
  } state_t;

  // Origin sits at the screen centre; y is flipped so up is positive.
  function automatic int centre_x(input int h_display);
    return h_display / 2;
  endfunction

  function automatic int centre_y(input int v_display);
    return v_display / 2 - 1;
  endfunction

endpackage

// File: rtl/orbit_trail_plotter_trail_ring.sv
// Ring buffer of plotted framebuffer addresses, oldest at the head; one push or pop per cycle.
// head_dat_o already looks past an entry being popped this cycle so the next erase can be issued back-to-back.
module trail_ring
  import orbit_plot_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push_i,
  input  logic [FB_ADDR_W-1:0] push_dat_i,
  input  logic                 pop_i,
  output logic [FB_ADDR_W-1:0] head_dat_o,
  output logic [CNT_W-1:0]     count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [FB_ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_inc;
  logic [CNT_W-1:0]     count_q, count_d;

  assign rd_ptr_inc = rd_ptr_q + PTR_W'(1);
  assign head_dat_o = pop_i ? mem_q[rd_ptr_inc] : mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d  = count_q + CNT_W'(1);
    end else if (pop_i) begin
      rd_ptr_d = rd_ptr_inc;
      count_d  = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

endmodule

// File: rtl/orbit_trail_plotter.sv
// Maps integrator positions to 1-bpp framebuffer writes, keeping a TRAIL_LEN comet tail (erase oldest, draw newest).
// Draw visible 2 cycles after accept (3 when full); ready drops while busy; ORBIT_PLOT_DEDUP_EN drops repeat addresses.
module orbit_trail_plotter
  import orbit_plot_pkg::*;
#(
  parameter int TRAIL_LEN = 64,
  parameter int POS_SHIFT = 16,
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           pos_valid,
  output logic                           pos_ready,
  input  logic [31:0]                    pos_x,
  input  logic [31:0]                    pos_y,
  input  logic                           clear,
  output logic                           fb_we,
  output logic [FB_ADDR_W-1:0]           fb_addr,
  output logic                           fb_data,
  output logic [$clog2(TRAIL_LEN+1)-1:0] trail_count,
  output logic                           busy
);

  localparam int CNT_W = $clog2(TRAIL_LEN + 1);
  localparam logic signed [31:0] CX = centre_x(H_DISPLAY);
  localparam logic signed [31:0] CY = centre_y(V_DISPLAY);
  localparam logic signed [31:0] HD = H_DISPLAY;
  localparam logic signed [31:0] VD = V_DISPLAY;

  state_t               state_q, state_d;
  logic signed [31:0]   x_q, x_d, y_q, y_d;
  logic [FB_ADDR_W-1:0] addr_q, addr_d;
  logic                 clear_pend_q, clear_pend_d;
  logic                 pos_ready_q, pos_ready_d;
  logic                 busy_q, busy_d;
  logic                 fb_we_q, fb_we_d;
  logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic                 fb_data_q, fb_data_d;

  logic signed [31:0]   px, py;
  logic [FB_ADDR_W-1:0] addr_new;
  logic                 on_screen, dup;
  logic                 ring_push, ring_pop, ring_full, ring_empty;
  logic [FB_ADDR_W-1:0] ring_head;
  logic [CNT_W-1:0]     ring_count;

  assign px        = (x_q >>> POS_SHIFT) + CX;
  assign py        = CY - (y_q >>> POS_SHIFT);
  assign on_screen = (px >= 0) && (px < HD) && (py >= 0) && (py < VD);
  assign addr_new  = FB_ADDR_W'(py) * FB_ADDR_W'(H_DISPLAY) + FB_ADDR_W'(px);

  // Push/pop follow the write currently on the bus, one cycle after it was scheduled.
  assign ring_push = (state_q == ST_DRAW);
  assign ring_pop  = (state_q == ST_ERASE) || ((state_q == ST_CLEAR) && fb_we_q);

`ifdef ORBIT_PLOT_DEDUP_EN
  logic [FB_ADDR_W-1:0] last_q, last_d;
  logic                 last_vld_q, last_vld_d;

  assign dup        = last_vld_q && (addr_new == last_q);
  assign last_d     = (state_q == ST_DRAW) ? addr_q : last_q;
  assign last_vld_d = (state_q == ST_CLEAR) ? 1'b0 : (last_vld_q || (state_q == ST_DRAW));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
  end
`else
  assign dup = 1'b0;
`endif

  trail_ring #(
    .DEPTH (TRAIL_LEN),
    .CNT_W (CNT_W)
  ) u_ring (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (ring_push),
    .push_dat_i (addr_q),
    .pop_i      (ring_pop),
    .head_dat_o (ring_head),
    .count_o    (ring_count),
    .full_o     (ring_full),
    .empty_o    (ring_empty)
  );

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    fb_we_d      = 1'b0;
    fb_data_d    = 1'b0;
    fb_addr_d    = fb_addr_q;
    // IDLE consumes a clear directly; elsewhere it waits in clear_pend.
    clear_pend_d = (state_q == ST_IDLE) ? 1'b0 : (clear_pend_q || clear);
    case (state_q)
      ST_IDLE: begin
        if (clear_pend_q || clear) begin
          state_d = ST_CLEAR;
          if (!ring_empty) begin
            fb_we_d   = 1'b1;
            fb_addr_d = ring_head;
          end
        end else if (pos_valid && pos_ready_q) begin
          x_d     = pos_x;
          y_d     = pos_y;
          state_d = ST_MAP;
        end
      end
      ST_MAP: begin
        if (on_screen && !dup) begin
          addr_d  = addr_new;
          fb_we_d = 1'b1;
          if (ring_full) begin
            state_d   = ST_ERASE;
            fb_addr_d = ring_head;
          end else begin
            state_d   = ST_DRAW;
            fb_data_d = 1'b1;
            fb_addr_d = addr_new;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ERASE: begin
        state_d   = ST_DRAW;
        fb_we_d   = 1'b1;
        fb_data_d = 1'b1;
        fb_addr_d = addr_q;
      end
      ST_DRAW: state_d = ST_IDLE;
      ST_CLEAR: begin
        if (fb_we_q && (ring_count > CNT_W'(1))) begin
          fb_we_d   = 1'b1;
          fb_addr_d = ring_head;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pos_ready_d = (state_d == ST_IDLE) && !clear_pend_d;
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      clear_pend_q <= 1'b0;
      pos_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      clear_pend_q <= clear_pend_d;
      pos_ready_q  <= pos_ready_d;
      busy_q       <= busy_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
    end
  end

  assign pos_ready   = pos_ready_q;
  assign busy        = busy_q;
  assign fb_we       = fb_we_q;
  assign fb_addr     = fb_addr_q;
  assign fb_data     = fb_data_q;
  assign trail_count = ring_count;

endmodule

// File: tb/tb_orbit_trail_plotter.sv
// Directed bench for orbit_trail_plotter with a 4-entry trail; cycle k counts clock edges after the accepting edge.
module tb_orbit_trail_plotter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pos_valid;
  logic        pos_ready;
  logic [31:0] pos_x;
  logic [31:0] pos_y;
  logic        clear;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic        fb_data;
  logic [2:0]  trail_count;
  logic        busy;

  always #5 clk = ~clk;

  orbit_trail_plotter #(
    .TRAIL_LEN (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pos_valid   (pos_valid),
    .pos_ready   (pos_ready),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .clear       (clear),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .trail_count (trail_count),
    .busy        (busy)
  );

  typedef struct {
    int x;
    int y;
    int nw;
    int c0;
    int a0;
    int d0;
    int c1;
    int a1;
    int d1;
    int rdy;
    int cnt;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   n_wr;
  int   rdy_cyc;
  int   cnt_at_rdy;
  int   wr_cyc  [8];
  int   wr_addr [8];
  int   wr_dat  [8];
  logic busy_c1;
  vec_t vecs [11];

  function automatic vec_t mk(input int x, input int y, input int nw,
                              input int c0, input int a0, input int d0,
                              input int c1, input int a1, input int d1,
                              input int rdy, input int cnt);
    vec_t v;
    v.x = x; v.y = y; v.nw = nw;
    v.c0 = c0; v.a0 = a0; v.d0 = d0;
    v.c1 = c1; v.a1 = a1; v.d1 = d1;
    v.rdy = rdy; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int idx, input int cyc, input int addr, input int dat);
    if (idx >= n_wr) begin
      checks++;
      errors++;
      $display("FAIL %s_write%0d actual=missing expected=cycle %0d addr %0d", tag, idx, cyc, addr);
    end else begin
      chk($sformatf("%s_w%0d_cycle", tag, idx), wr_cyc[idx], cyc);
      chk($sformatf("%s_w%0d_addr", tag, idx), wr_addr[idx], addr);
      chk($sformatf("%s_w%0d_data", tag, idx), wr_dat[idx], dat);
    end
  endtask

  task automatic sample(input int k);
    if (k == 1) busy_c1 = busy;
    if (fb_we && n_wr < 8) begin
      wr_cyc[n_wr]  = k;
      wr_addr[n_wr] = int'(fb_addr);
      wr_dat[n_wr]  = int'(fb_data);
      n_wr++;
    end
    if (pos_ready && rdy_cyc < 0) begin
      rdy_cyc    = k;
      cnt_at_rdy = int'(trail_count);
    end
  endtask

  task automatic watch(input int ncyc);
    n_wr = 0; rdy_cyc = -1; cnt_at_rdy = -1; busy_c1 = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      sample(k);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!pos_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!pos_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 expected=1");
    end
  endtask

  task automatic send(input int x, input int y);
    wait_ready();
    pos_x = x;
    pos_y = y;
    pos_valid = 1'b1;
    @(posedge clk);
    #1 pos_valid = 1'b0;
  endtask

  task automatic clear_pulse();
    wait_ready();
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int acc_cyc;
    int cnt7;
    int exp_nw;

    vecs[0]  = mk(0, 0,                    1, 2, 153280, 1, 0, 0, 0,      3, 1);
    vecs[1]  = mk(1*65536, 0,              1, 2, 153281, 1, 0, 0, 0,      3, 2);
    vecs[2]  = mk(2*65536, 0,              1, 2, 153282, 1, 0, 0, 0,      3, 3);
    vecs[3]  = mk(3*65536, 0,              1, 2, 153283, 1, 0, 0, 0,      3, 4);
    vecs[4]  = mk(4*65536, 0,              2, 2, 153280, 0, 3, 153284, 1, 4, 4);
    vecs[5]  = mk(400*65536, 0,            0, 0, 0, 0,      0, 0, 0,      2, 4);
    vecs[6]  = mk(-320*65536, 239*65536,   2, 2, 153281, 0, 3, 0, 1,      4, 4);
    vecs[7]  = mk(319*65536, -240*65536,   2, 2, 153282, 0, 3, 307199, 1, 4, 4);
    vecs[8]  = mk(-321*65536, 0,           0, 0, 0, 0,      0, 0, 0,      2, 4);
    vecs[9]  = mk(0, 240*65536,            0, 0, 0, 0,      0, 0, 0,      2, 4);
    vecs[10] = mk(65535, -1,               2, 2, 153283, 0, 3, 153920, 1, 4, 4);

    reset_n = 1'b0; pos_valid = 1'b0; clear = 1'b0; pos_x = '0; pos_y = '0;
    repeat (3) @(negedge clk);
    chk("rst_pos_ready", pos_ready, 0);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_fb_data", fb_data, 0);
    chk("rst_trail_count", trail_count, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_pos_ready", pos_ready, 1);
    chk("rel_trail_count", trail_count, 0);
    chk("rel_busy", busy, 0);

    for (int i = 0; i < 11; i++) begin
      send(vecs[i].x, vecs[i].y);
      watch(6);
      chk($sformatf("v%0d_nwrites", i), n_wr, vecs[i].nw);
      chk($sformatf("v%0d_busy", i), busy_c1, 1);
      chk($sformatf("v%0d_ready_cycle", i), rdy_cyc, vecs[i].rdy);
      chk($sformatf("v%0d_count", i), cnt_at_rdy, vecs[i].cnt);
      if (vecs[i].nw > 0) chk_wr($sformatf("v%0d", i), 0, vecs[i].c0, vecs[i].a0, vecs[i].d0);
      if (vecs[i].nw > 1) chk_wr($sformatf("v%0d", i), 1, vecs[i].c1, vecs[i].a1, vecs[i].d1);
    end

    // Full trail cleared oldest first.
    clear_pulse();
    watch(6);
    chk("clr4_nwrites", n_wr, 4);
    chk_wr("clr4", 0, 1, 153284, 0);
    chk_wr("clr4", 1, 2, 0, 0);
    chk_wr("clr4", 2, 3, 307199, 0);
    chk_wr("clr4", 3, 4, 153920, 0);
    chk("clr4_ready_cycle", rdy_cyc, 5);
    chk("clr4_count", cnt_at_rdy, 0);

    // Empty clear: one cycle in CLEAR, no writes.
    clear_pulse();
    watch(4);
    chk("clr0_nwrites", n_wr, 0);
    chk("clr0_busy", busy_c1, 1);
    chk("clr0_ready_cycle", rdy_cyc, 2);

    for (int j = 0; j < 3; j++) begin
      send((10 + j) * 65536, 0);
      watch(6);
      chk($sformatf("p%0d_nwrites", j), n_wr, 1);
      chk_wr($sformatf("p%0d", j), 0, 2, 153290 + j, 1);
      chk($sformatf("p%0d_count", j), cnt_at_rdy, j + 1);
    end

    // Clear raised with a sample: the sample waits until the trail is empty.
    wait_ready();
    clear = 1'b1; pos_valid = 1'b1; pos_x = 5 * 65536; pos_y = 0;
    @(posedge clk);
    #1 clear = 1'b0;
    n_wr = 0; rdy_cyc = -1; cnt_at_rdy = -1; acc_cyc = -1; cnt7 = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      sample(k);
      if (k == 7) cnt7 = int'(trail_count);
      if (pos_valid && pos_ready) begin
        acc_cyc = k;
        @(posedge clk);
        #1 pos_valid = 1'b0;
      end
    end
    pos_valid = 1'b0;
    chk("cv_nwrites", n_wr, 4);
    chk_wr("cv", 0, 1, 153290, 0);
    chk_wr("cv", 1, 2, 153291, 0);
    chk_wr("cv", 2, 3, 153292, 0);
    chk_wr("cv", 3, 6, 153285, 1);
    chk("cv_ready_cycle", rdy_cyc, 4);
    chk("cv_count_at_ready", cnt_at_rdy, 0);
    chk("cv_accept_cycle", acc_cyc, 4);
    chk("cv_count_after", cnt7, 1);

    // Repeat of the last drawn sample.
    send(5 * 65536, 0);
    watch(6);
`ifdef ORBIT_PLOT_DEDUP_EN
    exp_nw = 1;
    chk("dup_nwrites", n_wr, 0);
    chk("dup_ready_cycle", rdy_cyc, 2);
    chk("dup_count", cnt_at_rdy, 1);
`else
    exp_nw = 2;
    chk("dup_nwrites", n_wr, 1);
    chk_wr("dup", 0, 2, 153285, 1);
    chk("dup_ready_cycle", rdy_cyc, 3);
    chk("dup_count", cnt_at_rdy, 2);
`endif

    // Clear forgets the last drawn address, so the same sample draws again.
    clear_pulse();
    watch(6);
    chk("clr_dup_nwrites", n_wr, exp_nw);
    chk_wr("clr_dup", 0, 1, 153285, 0);
    chk("clr_dup_ready_cycle", rdy_cyc, exp_nw + 1);
    chk("clr_dup_count", cnt_at_rdy, 0);
    send(5 * 65536, 0);
    watch(6);
    chk("redraw_nwrites", n_wr, 1);
    chk_wr("redraw", 0, 2, 153285, 1);
    chk("redraw_count", cnt_at_rdy, 1);

    // Reset asserted while the draw write is on the bus.
    send(0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_fb_we_before", fb_we, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_fb_we", fb_we, 0);
    chk("mid_fb_addr", fb_addr, 0);
    chk("mid_fb_data", fb_data, 0);
    chk("mid_pos_ready", pos_ready, 0);
    chk("mid_busy", busy, 0);
    chk("mid_trail_count", trail_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_ready", pos_ready, 1);
    chk("mid_rel_count", trail_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
